// File: rtl/memc3_reset_sequencer.sv
// memc3_reset_sequencer: holds user logic in reset until the memory is
// locked, calibrated and stable. It pulses mcb_rst_req to retry a
// calibration timeout and latches a fault once the retries are used up.
//
// Ports:
//   clk0        fabric clock
//   sys_rst_n   async active-low reset
//   pll_lock    PLL lock, asynchronous, synchronised here
//   rst0        infrastructure reset, clk0 domain
//   calib_done  MCB calibration done, synchronised here
//   user_rst    reset to user logic
//   ready       memory usable
//   mcb_rst_req reset request to the infrastructure
//   fault       retries exhausted
//   retry_cnt   retries performed, saturating
//   state_dbg   FSM state
module memc3_reset_sequencer #(
    parameter int CALIB_TIMEOUT = 1000000,
    parameter int RELEASE_DLY   = 16,
    parameter int RESET_PULSE   = 32,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 24
) (
    input  logic       clk0,
    input  logic       sys_rst_n,
    input  logic       pll_lock,
    input  logic       rst0,
    input  logic       calib_done,
    output logic       user_rst,
    output logic       ready,
    output logic       mcb_rst_req,
    output logic       fault,
    output logic [1:0] retry_cnt,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        WAIT_CAL  = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        REQ       = 3'd4,
        FAULT     = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(CALIB_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_DLY - 1);
    localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(RESET_PULSE - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       retry_nxt;
    logic             lk_m;
    logic             lk_s;
    logic             cd_m;
    logic             cd_s;

    // cnt is the release counter in RELEASE and the pulse counter in REQ.
    always_comb begin
        nxt       = state;
        timer_nxt = timer;
        cnt_nxt   = cnt;
        retry_nxt = retry_cnt;
        unique case (state)
            WAIT_LOCK, WAIT_CAL: begin
                timer_nxt = timer + ONE;
                // Timeout wins over any lock/calibration progress.
                if (timer == TO_LAST) begin
                    cnt_nxt = '0;
                    if (int'(retry_cnt) < MAX_RETRY) begin
                        nxt       = REQ;
                        retry_nxt = (retry_cnt == 2'd3) ? 2'd3
                                                        : retry_cnt + 2'd1;
                    end else begin
                        nxt = FAULT;
                    end
                end else if (state == WAIT_LOCK) begin
                    if (lk_s && !rst0) nxt = WAIT_CAL;
                end else if (cd_s) begin
                    nxt     = RELEASE;
                    cnt_nxt = '0;
                end else if (!lk_s) begin
                    nxt = WAIT_LOCK;
                end
            end
            RELEASE: begin
                if (!cd_s) begin
                    nxt     = WAIT_CAL;
                    cnt_nxt = '0;
                end else if (cnt == REL_LAST) begin
                    nxt = RUN;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            RUN: begin
                // Losing lock alone is tolerated while running.
                if (!cd_s || rst0) begin
                    nxt       = WAIT_LOCK;
                    timer_nxt = '0;
                end
            end
            REQ: begin
                if (cnt == REQ_LAST) begin
                    nxt       = WAIT_LOCK;
                    timer_nxt = '0;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            FAULT: nxt = FAULT;
            default: nxt = FAULT;
        endcase
    end

    always_ff @(posedge clk0 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lk_m        <= 1'b0;
            lk_s        <= 1'b0;
            cd_m        <= 1'b0;
            cd_s        <= 1'b0;
            state       <= WAIT_LOCK;
            timer       <= '0;
            cnt         <= '0;
            retry_cnt   <= 2'd0;
            user_rst    <= 1'b1;
            ready       <= 1'b0;
            mcb_rst_req <= 1'b0;
            fault       <= 1'b0;
            state_dbg   <= 3'd0;
        end else begin
            lk_m        <= pll_lock;
            lk_s        <= lk_m;
            cd_m        <= calib_done;
            cd_s        <= cd_m;
            state       <= nxt;
            timer       <= timer_nxt;
            cnt         <= cnt_nxt;
            retry_cnt   <= retry_nxt;
            user_rst    <= (nxt != RUN);
            ready       <= (nxt == RUN);
            mcb_rst_req <= (nxt == REQ);
            fault       <= (nxt == FAULT);
            state_dbg   <= nxt;
        end
    end

endmodule
